out_byte_uart_tx: RTL



---
 rtl/out_byte_uart_tx_if.sv | 35 +++
 rtl/out_byte_uart_tx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/out_byte_uart_tx_if.sv
// out_byte_uart_tx_if: groups the core-side byte port and the line/status
// signals of the byte-stream UART transmitter.
//   out_byte    [7:0] byte from the core, valid while out_byte_en = 1
//   out_byte_en       one-cycle write strobe, back-to-back highs allowed
//   uart_tx           serial line, idles high
//   busy              frame on the line or bytes queued
//   fifo_full         FIFO holds FIFO_DEPTH entries
//   overflow          sticky dropped-byte flag
// master = core/bench side, slave = transmitter side.
interface out_byte_uart_tx_if;
    logic [7:0] out_byte;
    logic       out_byte_en;
    logic       uart_tx;
    logic       busy;
    logic       fifo_full;
    logic       overflow;

    modport master (
        output out_byte,
        output out_byte_en,
        input  uart_tx,
        input  busy,
        input  fifo_full,
        input  overflow
    );

    modport slave (
        input  out_byte,
        input  out_byte_en,
        output uart_tx,
        output busy,
        output fifo_full,
        output overflow
    );
endinterface

// File: rtl/out_byte_uart_tx.sv
// out_byte_uart_tx: queues bytes strobed by the core in a small FIFO and
// serialises them onto a UART pin as 8N1 frames, LSB first.
//   clk  sole clock, rising edge
//   rst  synchronous, active-high reset
//   bus  out_byte_uart_tx_if.slave
//          in : out_byte[7:0], out_byte_en
//          out: uart_tx, busy, fifo_full, overflow (all registered)
module out_byte_uart_tx #(
    parameter int unsigned CLK_HZ     = 27_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    out_byte_uart_tx_if.slave bus
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned AW           = $clog2(FIFO_DEPTH);
    localparam int unsigned PW           = AW + 1;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    // FSM and datapath registers
    state_e          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;

    // FIFO pointers carry one extra wrap bit to tell full from empty
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    // Registered outputs
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            full_q, full_d;
    logic            overflow_q, overflow_d;

    // Combinational helpers
    logic            empty_c;
    logic            push_c;
    logic            drop_c;
    logic            pop_c;
    logic            baud_last_c;
    logic [7:0]      head_c;

    assign empty_c     = (wr_ptr_q == rd_ptr_q);
    // Full is judged on pre-edge state, so a pop on the same edge cannot
    // make room for a strobe that arrives while full.
    assign push_c      = bus.out_byte_en && !full_q;
    assign drop_c      = bus.out_byte_en && full_q;
    assign baud_last_c = (baud_q == BAUD_LAST);
    assign head_c      = mem_q[rd_ptr_q[AW-1:0]];

    // Next-state logic for the frame sequencer
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Baud counter is parked at zero while idle
                baud_d = '0;
                bit_d  = '0;
                if (!empty_c) begin
                    pop_c   = 1'b1;
                    shift_d = head_c;
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (baud_last_c) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end

            ST_DATA: begin
                if (baud_last_c) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end

            ST_STOP: begin
                if (baud_last_c) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more is queued
                    if (!empty_c) begin
                        pop_c   = 1'b1;
                        shift_d = head_c;
                        bit_d   = '0;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Pointer, flag and line next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(push_c);
        rd_ptr_d   = rd_ptr_q + PW'(pop_c);
        full_d     = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                     (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        overflow_d = overflow_q | drop_c;
        // busy also covers the cycle the final stop bit is still leaving
        // the line flop after the sequencer has returned to idle.
        busy_d     = (state_d != ST_IDLE) || (state_q != ST_IDLE) ||
                     (wr_ptr_d != rd_ptr_d);

        tx_d = 1'b1;
        case (state_q)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_q[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents are don't-care until a pointer covers them
    always_ff @(posedge clk) begin
        if (push_c && !rst) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.out_byte;
        end
    end

    assign bus.uart_tx   = tx_q;
    assign bus.busy      = busy_q;
    assign bus.fifo_full = full_q;
    assign bus.overflow  = overflow_q;

endmodule
